// File: rtl/mem_loader.sv
// ============================================================================
// mem_loader
// ----------------------------------------------------------------------------
// Byte-stream program loader sitting in front of the 256x8 unified memory.
// Frames arrive over a valid/ready byte handshake:
//
//     SYNC_BYTE(8'hA5), ADDR, LEN, LEN data bytes, CHK
//
// LEN = 0 stands for 256 bytes. CHK is the XOR of ADDR, LEN and every data
// byte. Each data byte is written to memory through a one-cycle write pulse
// at consecutive addresses starting at ADDR, with 8-bit wrap-around.
//
// Ports
//   clk       in   1  single clock, all state changes on posedge
//   rst       in   1  asynchronous, active-high reset
//   in_data   in   8  incoming stream byte
//   in_valid  in   1  in_data is valid
//   in_ready  out  1  loader accepts a byte this cycle (low only in WR)
//   mem_addr  out  8  memory write address
//   mem_din   out  8  memory write data
//   mem_we    out  1  memory write enable, one-cycle pulses only
//   busy      out  1  a frame is in progress, CPU must keep off the memory
//   done      out  1  one-cycle pulse, frame finished with a good checksum
//   err       out  1  sticky checksum failure, cleared by the next sync byte
// ============================================================================
module mem_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_we,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Frame-parsing states.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_CHK  = 3'd5;

    logic [2:0] state;
    logic [7:0] ptr;        // next memory address to write
    logic [8:0] cnt;        // data bytes still expected (256 needs 9 bits)
    logic [7:0] xor_acc;    // running checksum over ADDR, LEN and data
    logic       accept;     // a byte transfers on this clock edge

    // The WR cycle is where the memory captures the byte, so the stream is
    // stalled there. in_ready depends on the state register only, which
    // keeps the handshake free of any combinational path from in_valid.
    assign in_ready = (state != ST_WR);
    assign accept   = in_valid & in_ready;

    // NOTE: every register here, including the memory-port outputs, is reset
    // asynchronously so that an aborted frame drops mem_we and busy at once;
    // the memory array itself lives outside and keeps what was written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= 8'h00;
            cnt      <= 9'd0;
            xor_acc  <= 8'h00;
            mem_addr <= 8'h00;
            mem_din  <= 8'h00;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below
            // are overridden later in the same block, and the last write wins.
            done   <= 1'b0;
            mem_we <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Anything but the sync marker is line noise and dropped.
                    if (accept && in_data == SYNC_BYTE) begin
                        state <= ST_ADDR;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                ST_ADDR: begin
                    if (accept) begin
                        ptr     <= in_data;
                        xor_acc <= in_data;
                        state   <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (accept) begin
                        cnt     <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                        xor_acc <= xor_acc ^ in_data;
                        state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    // A byte equal to SYNC_BYTE here is plain payload.
                    if (accept) begin
                        mem_addr <= ptr;
                        mem_din  <= in_data;
                        mem_we   <= 1'b1;
                        xor_acc  <= xor_acc ^ in_data;
                        ptr      <= ptr + 8'd1;
                        cnt      <= cnt - 9'd1;
                        state    <= ST_WR;
                    end
                end

                ST_WR: begin
                    // mem_we already falls through the default above.
                    state <= (cnt == 9'd0) ? ST_CHK : ST_DATA;
                end

                ST_CHK: begin
                    // Written bytes are not rolled back on a bad checksum.
                    if (accept) begin
                        if (in_data == xor_acc) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
